// File: rtl/fifo_ctrl_if.sv
// Handshake/status bundle between a FIFO requester and the fifo_ctrl pointer controller.
interface fifo_ctrl_if #(
  parameter int mem_depth = 32,
  parameter int AF_LEVEL  = 28
);
  localparam int AW = $clog2(mem_depth);

  logic          push;
  logic          pop;
  logic          wren;
  logic [AW-1:0] wraddress;
  logic          rden;
  logic [AW-1:0] rdaddress;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop,
    input  wren, wraddress, rden, rdaddress, rd_valid,
    input  full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, pop,
    output wren, wraddress, rden, rdaddress, rd_valid,
    output full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller turning a registered-output dual-port RAM into a synchronous FIFO.
// Read latency 1 cycle (rd_valid aligned with RAM data_out); requests are rejected, not stalled, at full/empty.
module fifo_ctrl #(
  parameter int mem_depth = 32,
  parameter int AF_LEVEL  = 28
) (
  input  logic         clock,
  input  logic         reset,
  fifo_ctrl_if.slave   bus
);
  localparam int AW = $clog2(mem_depth);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_count;
  logic        r_rd_valid;
  logic        r_overflow;
  logic        r_underflow;

  logic        w_full;
  logic        w_empty;
  logic        w_wren;
  logic        w_rden;

  // Flags come from pointers only, so pop never reaches wren and push never reaches rden.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wren  = bus.push && !w_full;
  assign w_rden  = bus.pop && !w_empty;

  assign bus.wren        = w_wren;
  assign bus.rden        = w_rden;
  assign bus.wraddress   = r_wr_ptr[AW-1:0];
  assign bus.rdaddress   = r_rd_ptr[AW-1:0];
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.count       = r_count;
  assign bus.almost_full = (r_count >= (AW+1)'(AF_LEVEL));
  assign bus.rd_valid    = r_rd_valid;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wren) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rden) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_wren, w_rden})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid  <= w_rden;
      r_overflow  <= bus.push && w_full;
      r_underflow <= bus.pop && w_empty;
    end
  end

  a_count_matches_ptrs: assert property (@(posedge clock) disable iff (reset)
    r_count == (r_wr_ptr - r_rd_ptr));
  a_no_same_addr: assert property (@(posedge clock) disable iff (reset)
    !(w_wren && w_rden && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0])));
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed and random checks of fifo_ctrl against a queue model, with a behavioural registered-output RAM.
module tb_fifo_ctrl;
  localparam int DEPTH = 32;
  localparam int AFL   = 28;
  localparam int AW    = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fifo_ctrl_if #(.mem_depth(DEPTH), .AF_LEVEL(AFL)) bus();
  fifo_ctrl #(.mem_depth(DEPTH), .AF_LEVEL(AFL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM_DP stand-in: registered read, no write-to-read bypass.
  logic [15:0] mem [DEPTH];
  logic [15:0] ram_dout;
  logic [15:0] din;
  always @(posedge clock) begin
    if (bus.wren) mem[bus.wraddress] <= din;
    if (bus.rden) ram_dout <= mem[bus.rdaddress];
  end

  logic [15:0] mq [$];
  logic [15:0] next_dat;
  int m_cnt, m_wr, m_rd;
  int n_pass, n_checks;

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0;
    m_wr  = 0;
    m_rd  = 0;
  endtask

  // Called at posedge+1; drives one cycle of requests and checks both the combinational and registered response.
  task automatic step(input logic p, input logic q);
    logic was_full, was_empty, ew, er;
    logic [15:0] ed;
    was_full  = (m_cnt == DEPTH);
    was_empty = (m_cnt == 0);
    ew = p && !was_full;
    er = q && !was_empty;
    bus.push = p;
    bus.pop  = q;
    din      = next_dat;
    #1;
    check("wren", bus.wren, ew);
    check("rden", bus.rden, er);
    check("wraddress", bus.wraddress, m_wr % DEPTH);
    check("rdaddress", bus.rdaddress, m_rd % DEPTH);
    check("same_addr", bus.wren && bus.rden && (bus.wraddress == bus.rdaddress), 0);
    ed = '0;
    if (ew) begin
      mq.push_back(din);
      next_dat++;
      m_wr = (m_wr + 1) % (2 * DEPTH);
      m_cnt++;
    end
    if (er) begin
      ed   = mq.pop_front();
      m_rd = (m_rd + 1) % (2 * DEPTH);
      m_cnt--;
    end
    @(posedge clock);
    #1;
    check("count", bus.count, m_cnt);
    check("full", bus.full, m_cnt == DEPTH);
    check("empty", bus.empty, m_cnt == 0);
    check("almost_full", bus.almost_full, m_cnt >= AFL);
    check("overflow", bus.overflow, p && was_full);
    check("underflow", bus.underflow, q && was_empty);
    check("rd_valid", bus.rd_valid, er);
    if (er) check("rd_data", ram_dout, ed);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    reset = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    din = '0;
    next_dat = 16'h0100;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_af", bus.almost_full, 0);
    check("rst_wren", bus.wren, 0);
    check("rst_rden", bus.rden, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_underflow", bus.underflow, 0);
    reset = 1'b0;

    // Fill to full, watching the almost_full threshold.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0);
      if (i == AFL - 2) check("af_at_27", bus.almost_full, 0);
      if (i == AFL - 1) check("af_at_28", bus.almost_full, 1);
    end
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 32);

    step(1'b1, 1'b0);
    check("ovf_pulse", bus.overflow, 1);
    check("ovf_count", bus.count, 32);
    step(1'b0, 1'b0);
    check("ovf_one_cycle", bus.overflow, 0);

    step(1'b1, 1'b1);
    check("pp_full_count", bus.count, 31);
    check("pp_full_ovf", bus.overflow, 1);
    step(1'b1, 1'b0);

    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1);
    check("drain_empty", bus.empty, 1);
    step(1'b0, 1'b0);
    check("drain_rv_low", bus.rd_valid, 0);

    step(1'b0, 1'b1);
    check("unf_pulse", bus.underflow, 1);
    step(1'b0, 1'b0);
    check("unf_one_cycle", bus.underflow, 0);

    step(1'b1, 1'b1);
    check("pp_empty_count", bus.count, 1);
    check("pp_empty_unf", bus.underflow, 1);
    check("pp_empty_rv", bus.rd_valid, 0);
    step(1'b0, 1'b0);
    check("pp_empty_rv_next", bus.rd_valid, 0);

    // Concurrent traffic at count 3 walks both pointers across the wrap.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    check("wrap_count", bus.count, 3);

    // Asynchronous reset mid-cycle while rd_valid is high.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("pre_rst_rv", bus.rd_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", bus.count, 0);
    check("arst_empty", bus.empty, 1);
    check("arst_rd_valid", bus.rd_valid, 0);
    check("arst_wraddress", bus.wraddress, 0);
    check("arst_rdaddress", bus.rdaddress, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Random stress with alternating fill-biased and drain-biased phases.
    for (int c = 0; c < 10000; c++) begin
      logic p, q;
      if (((c / 400) % 2) == 0) begin
        p = ($urandom_range(99) < 75);
        q = ($urandom_range(99) < 30);
      end else begin
        p = ($urandom_range(99) < 30);
        q = ($urandom_range(99) < 75);
      end
      step(p, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
